// File: rtl/front_panel_ctrl.sv
// PDP-8 front panel: synchronized buttons drive deposit / load-address / load-AC actions.
// Optional switch debouncing is built in when FP_DEBOUNCE_EN is defined.
module front_panel_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ADDR_W          = 12
) (
    input  logic              clk,
    input  logic              btnCpuReset,
    input  logic [ADDR_W:0]   sw,
    input  logic              btn_deposit,
    input  logic              btn_load_pc,
    input  logic              btn_load_ac,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] write_data,
    input  logic              mem_finished,
    output logic              pc_load_en,
    output logic [ADDR_W-1:0] pc_value,
    output logic              ac_load_en,
    output logic [ADDR_W-1:0] ac_value,
    output logic              run,
    output logic              busy
);

    typedef enum logic [1:0] {FP_IDLE, FP_WRITE, FP_WAIT, FP_INC} fp_state_e;

    fp_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] data_q, data_d;
    logic              pc_en_q, pc_en_d;
    logic [ADDR_W-1:0] pc_val_q, pc_val_d;
    logic              ac_en_q, ac_en_d;
    logic [ADDR_W-1:0] ac_val_q, ac_val_d;

    // Bit order: 0 deposit, 1 load_pc, 2 load_ac, 3 run switch.
    logic [3:0] sync1_q, sync2_q;
    logic [1:0] settle_q;
    logic [2:0] armed_q, prev_q;
    logic [2:0] level, btn_edge;
    logic       dep_ev, pc_ev, ac_ev;

    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sw[ADDR_W], btn_load_ac, btn_load_pc, btn_deposit};
            sync2_q <= sync1_q;
        end
    end

`ifdef FP_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt_q [3];
    logic [2:0]       db_lvl_q;

    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            db_lvl_q <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2_q[i] == db_lvl_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_lvl_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign level = db_lvl_q;
`else
    assign level = sync2_q[2:0];
`endif

    // A button is armed only once its synchronized level has been seen low after
    // the synchronizers have refilled, so a press held across reset cannot fire.
    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            settle_q <= '0;
            armed_q  <= '0;
            prev_q   <= '0;
        end else begin
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            armed_q <= armed_q | ({3{settle_q == 2'd2}} & ~sync2_q[2:0]);
            prev_q  <= level;
        end
    end

    assign btn_edge = level & ~prev_q & armed_q;
    assign run      = sync2_q[3];
    assign dep_ev   = btn_edge[0] & ~run;
    assign pc_ev    = btn_edge[1] & ~run;
    assign ac_ev    = btn_edge[2] & ~run;

    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            state_q  <= FP_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            pc_en_q  <= 1'b0;
            pc_val_q <= '0;
            ac_en_q  <= 1'b0;
            ac_val_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            pc_en_q  <= pc_en_d;
            pc_val_q <= pc_val_d;
            ac_en_q  <= ac_en_d;
            ac_val_q <= ac_val_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        pc_en_d  = 1'b0;
        pc_val_d = pc_val_q;
        ac_en_d  = 1'b0;
        ac_val_d = ac_val_q;

        if (ac_ev) begin
            ac_en_d  = 1'b1;
            ac_val_d = sw[ADDR_W-1:0];
        end

        unique case (state_q)
            FP_IDLE: begin
                // load_pc takes priority; a simultaneous deposit is discarded.
                if (pc_ev) begin
                    addr_d   = sw[ADDR_W-1:0];
                    pc_en_d  = 1'b1;
                    pc_val_d = sw[ADDR_W-1:0];
                end else if (dep_ev) begin
                    data_d  = sw[ADDR_W-1:0];
                    state_d = FP_WRITE;
                end
            end
            FP_WRITE: state_d = FP_WAIT;
            FP_WAIT: begin
                if (mem_finished) state_d = FP_INC;
            end
            FP_INC: begin
                addr_d   = addr_q + ADDR_W'(1);
                pc_en_d  = 1'b1;
                pc_val_d = addr_q + ADDR_W'(1);
                state_d  = FP_IDLE;
            end
            default: state_d = FP_IDLE;
        endcase
    end

    assign write_enable = (state_q == FP_WRITE) || (state_q == FP_WAIT);
    assign busy         = (state_q != FP_IDLE);
    assign address      = addr_q;
    assign write_data   = data_q;
    assign pc_load_en   = pc_en_q;
    assign pc_value     = pc_val_q;
    assign ac_load_en   = ac_en_q;
    assign ac_value     = ac_val_q;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Scoreboard bench for front_panel_ctrl: expected writes and load pulses are queued
// as buttons are pressed and checked when the DUT emits them.
module tb_front_panel_ctrl;

    logic        clk = 1'b0;
    logic        btnCpuReset;
    logic [12:0] sw;
    logic        btn_deposit, btn_load_pc, btn_load_ac;
    logic        write_enable;
    logic [11:0] address, write_data;
    logic        mem_finished;
    logic        pc_load_en;
    logic [11:0] pc_value;
    logic        ac_load_en;
    logic [11:0] ac_value;
    logic        run, busy;

    always #5 clk = ~clk;

    front_panel_ctrl #(.DEBOUNCE_CYCLES(4), .ADDR_W(12)) dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .sw(sw),
        .btn_deposit(btn_deposit), .btn_load_pc(btn_load_pc), .btn_load_ac(btn_load_ac),
        .write_enable(write_enable), .address(address), .write_data(write_data),
        .mem_finished(mem_finished), .pc_load_en(pc_load_en), .pc_value(pc_value),
        .ac_load_en(ac_load_en), .ac_value(ac_value), .run(run), .busy(busy)
    );

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [11:0] exp_pc[$];
    logic [11:0] exp_ac[$];
    logic [11:0] mem [4096];
    wr_t         mon_wr;
    logic [11:0] mon_v;
    logic [11:0] model_addr = '0;
    int          errors = 0, checks = 0;
    int          we_rises = 0, pc_pulses = 0, ac_pulses = 0, we_cycles = 0;
    logic        we_prev = 1'b0, mem_hold = 1'b0, force_mem = 1'b0;

    // Monitor, scoreboard and memory responder.
    always @(negedge clk) begin
        if (write_enable && !we_prev) begin
            we_rises++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%o data=%o, expected no write", address, write_data);
            end else begin
                mon_wr = exp_wr.pop_front();
                if (address !== mon_wr.a || write_data !== mon_wr.d) begin
                    errors++;
                    $display("FAIL wr_value: got addr=%o data=%o, expected addr=%o data=%o",
                             address, write_data, mon_wr.a, mon_wr.d);
                end
            end
            mem[address] = write_data;
        end
        we_prev = write_enable;
        if (pc_load_en) begin
            pc_pulses++;
            checks++;
            if (exp_pc.size() == 0) begin
                errors++;
                $display("FAIL pc_unexpected: got pc_value=%o, expected no pulse", pc_value);
            end else begin
                mon_v = exp_pc.pop_front();
                if (pc_value !== mon_v) begin
                    errors++;
                    $display("FAIL pc_value: got %o, expected %o", pc_value, mon_v);
                end
            end
        end
        if (ac_load_en) begin
            ac_pulses++;
            checks++;
            if (exp_ac.size() == 0) begin
                errors++;
                $display("FAIL ac_unexpected: got ac_value=%o, expected no pulse", ac_value);
            end else begin
                mon_v = exp_ac.pop_front();
                if (ac_value !== mon_v) begin
                    errors++;
                    $display("FAIL ac_value: got %o, expected %o", ac_value, mon_v);
                end
            end
        end
        we_cycles    = write_enable ? we_cycles + 1 : 0;
        mem_finished = force_mem || (write_enable && !mem_hold && we_cycles >= 2);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which);
        if (which == 0) btn_deposit = 1'b1;
        else if (which == 1) btn_load_pc = 1'b1;
        else btn_load_ac = 1'b1;
        tick(4);
        btn_deposit = 1'b0;
        btn_load_pc = 1'b0;
        btn_load_ac = 1'b0;
        tick(4);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || exp_wr.size() != 0 || exp_pc.size() != 0 || exp_ac.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b pending=%0d, expected idle with 0 pending",
                     tag, busy, exp_wr.size() + exp_pc.size() + exp_ac.size());
            exp_wr.delete();
            exp_pc.delete();
            exp_ac.delete();
        end
    endtask

    task automatic do_load_pc(input logic [11:0] v);
        sw = {1'b0, v};
        exp_pc.push_back(v);
        model_addr = v;
        press(1);
        wait_done("load_pc");
    endtask

    task automatic do_deposit(input logic [11:0] v);
        wr_t e;
        sw  = {1'b0, v};
        e.a = model_addr;
        e.d = v;
        exp_wr.push_back(e);
        model_addr = model_addr + 12'd1;
        exp_pc.push_back(model_addr);
        press(0);
        wait_done("deposit");
    endtask

    task automatic test_reset;
        btnCpuReset = 1'b0;
        sw = '0;
        btn_deposit = 1'b0;
        btn_load_pc = 1'b0;
        btn_load_ac = 1'b0;
        tick(3);
        #1;
        checks += 5;
        if ({write_enable, pc_load_en, ac_load_en, run, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got we,pc,ac,run,busy=%b, expected 00000",
                     {write_enable, pc_load_en, ac_load_en, run, busy});
        end
        if (address !== 12'o0) begin errors++; $display("FAIL reset_address: got %o, expected 0000", address); end
        if (write_data !== 12'o0) begin errors++; $display("FAIL reset_data: got %o, expected 0000", write_data); end
        if (pc_value !== 12'o0) begin errors++; $display("FAIL reset_pc_value: got %o, expected 0000", pc_value); end
        if (ac_value !== 12'o0) begin errors++; $display("FAIL reset_ac_value: got %o, expected 0000", ac_value); end
        btnCpuReset = 1'b1;
        model_addr = '0;
        tick(4);
    endtask

    task automatic test_deposit_seq;
        int base;
        do_load_pc(12'o0200);
        base = we_rises;
        do_deposit(12'o7402);
        do_deposit(12'o1234);
        checks += 4;
        if (mem[12'o0200] !== 12'o7402) begin errors++; $display("FAIL seq_mem0200: got %o, expected 7402", mem[12'o0200]); end
        if (mem[12'o0201] !== 12'o1234) begin errors++; $display("FAIL seq_mem0201: got %o, expected 1234", mem[12'o0201]); end
        if (address !== 12'o0202) begin errors++; $display("FAIL seq_address: got %o, expected 0202", address); end
        if (we_rises - base != 2) begin errors++; $display("FAIL seq_handshakes: got %0d, expected 2", we_rises - base); end
    endtask

    task automatic test_wrap;
        do_load_pc(12'o7777);
        do_deposit(12'o0005);
        checks += 3;
        if (mem[12'o7777] !== 12'o0005) begin errors++; $display("FAIL wrap_mem: got %o, expected 0005", mem[12'o7777]); end
        if (address !== 12'o0000) begin errors++; $display("FAIL wrap_address: got %o, expected 0000", address); end
        if (pc_value !== 12'o0000) begin errors++; $display("FAIL wrap_pc_value: got %o, expected 0000", pc_value); end
    endtask

    task automatic test_same_cycle;
        int base = we_rises;
        sw = {1'b0, 12'o0100};
        exp_pc.push_back(12'o0100);
        model_addr = 12'o0100;
        btn_load_pc = 1'b1;
        btn_deposit = 1'b1;
        tick(4);
        btn_load_pc = 1'b0;
        btn_deposit = 1'b0;
        tick(4);
        wait_done("same_cycle");
        checks += 2;
        if (we_rises != base) begin errors++; $display("FAIL same_cycle_write: got %0d writes, expected 0", we_rises - base); end
        if (address !== 12'o0100) begin errors++; $display("FAIL same_cycle_address: got %o, expected 0100", address); end
    endtask

    task automatic test_stall;
        wr_t e;
        int base = we_rises;
        int n = 0;
        mem_hold = 1'b1;
        sw  = {1'b0, 12'o4321};
        e.a = model_addr;
        e.d = 12'o4321;
        exp_wr.push_back(e);
        model_addr = model_addr + 12'd1;
        exp_pc.push_back(model_addr);
        btn_deposit = 1'b1;
        tick(4);
        btn_deposit = 1'b0;
        while (!write_enable && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 20; i++) begin
            if (i == 4) begin sw = {1'b0, 12'o7070}; btn_deposit = 1'b1; end
            if (i == 8) btn_deposit = 1'b0;
            if (i == 11) begin sw = {1'b0, 12'o0055}; exp_ac.push_back(12'o0055); btn_load_ac = 1'b1; end
            if (i == 15) btn_load_ac = 1'b0;
            @(negedge clk);
            #1;
            checks++;
            if (write_enable !== 1'b1 || address !== 12'o0100 || write_data !== 12'o4321) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got we=%b addr=%o data=%o, expected we=1 addr=0100 data=4321",
                         i, write_enable, address, write_data);
            end
        end
        mem_hold = 1'b0;
        wait_done("stall");
        checks += 2;
        if (address !== 12'o0101) begin errors++; $display("FAIL stall_address: got %o, expected 0101", address); end
        if (we_rises - base != 1) begin errors++; $display("FAIL stall_dropped: got %0d writes, expected 1", we_rises - base); end
    endtask

    task automatic test_reset_wait;
        wr_t e;
        int n = 0;
        mem_hold = 1'b1;
        sw  = {1'b0, 12'o0666};
        e.a = model_addr;
        e.d = 12'o0666;
        exp_wr.push_back(e);
        press(0);
        while (!write_enable && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (write_enable !== 1'b1) begin errors++; $display("FAIL rstwait_enter: got we=%b, expected 1", write_enable); end
        @(negedge clk);
        btnCpuReset = 1'b0;
        @(posedge clk);
        #1;
        checks += 3;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL rstwait_we: got %b, expected 0", write_enable); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstwait_busy: got %b, expected 0", busy); end
        // The abandoned write leaves the address at its reset value, not 0102.
        if (address !== 12'o0000) begin errors++; $display("FAIL rstwait_address: got %o, expected 0000", address); end
        @(negedge clk);
        btnCpuReset = 1'b1;
        mem_hold = 1'b0;
        model_addr = '0;
        tick(4);
        wait_done("rstwait");
    endtask

    task automatic test_mem_outside_wait;
        force_mem = 1'b1;
        tick(4);
        #1;
        checks += 2;
        if (busy !== 1'b0 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL mem_idle_state: got busy=%b we=%b, expected 0 0", busy, write_enable);
        end
        if (address !== model_addr) begin errors++; $display("FAIL mem_idle_address: got %o, expected %o", address, model_addr); end
        force_mem = 1'b0;
        tick(2);
    endtask

    task automatic test_run;
        int bw = we_rises, bp = pc_pulses, ba = ac_pulses;
        sw = {1'b1, 12'o1111};
        tick(4);
        #1;
        checks++;
        if (run !== 1'b1) begin errors++; $display("FAIL run_level: got %b, expected 1", run); end
        press(0);
        press(1);
        press(2);
        tick(4);
        checks += 4;
        if (we_rises != bw) begin errors++; $display("FAIL run_write: got %0d writes, expected 0", we_rises - bw); end
        if (pc_pulses != bp) begin errors++; $display("FAIL run_pc: got %0d pulses, expected 0", pc_pulses - bp); end
        if (ac_pulses != ba) begin errors++; $display("FAIL run_ac: got %0d pulses, expected 0", ac_pulses - ba); end
        if (address !== model_addr) begin errors++; $display("FAIL run_address: got %o, expected %o", address, model_addr); end
        sw = {1'b0, 12'o1111};
        tick(4);
    endtask

    task automatic test_reset_held;
        int bp;
        btnCpuReset = 1'b0;
        sw = {1'b0, 12'o0777};
        btn_load_pc = 1'b1;
        tick(3);
        btnCpuReset = 1'b1;
        model_addr = '0;
        bp = pc_pulses;
        tick(10);
        checks++;
        if (pc_pulses != bp) begin errors++; $display("FAIL held_no_fire: got %0d pulses, expected 0", pc_pulses - bp); end
        btn_load_pc = 1'b0;
        tick(4);
        do_load_pc(12'o0777);
        checks += 2;
        if (pc_pulses != bp + 1) begin errors++; $display("FAIL held_repress: got %0d pulses, expected 1", pc_pulses - bp); end
        if (address !== 12'o0777) begin errors++; $display("FAIL held_address: got %o, expected 0777", address); end
    endtask

    initial begin
        mem_finished = 1'b0;
        test_reset();
        test_deposit_seq();
        test_wrap();
        test_same_cycle();
        test_stall();
        test_reset_wait();
        test_mem_outside_wait();
        test_run();
        test_reset_held();
        do_load_pc(12'o0010);
        do_deposit(12'o0123);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at 500000, expected completion");
        $fatal(1, "timeout");
    end

endmodule
